// File: rtl/next_pc_predictor_pkg.sv
// Shared types and helpers for the next-PC predictor: counter encoding,
// BTB entry layout, saturating counter updates and index-width derivation.
package next_pc_predictor_pkg;

  // Widest supported address. Entry fields are sized to this so that one
  // typedef serves every ADDR_W. The unused upper bits are always written
  // as zero and are trimmed by synthesis.
  localparam int unsigned MaxAddrW = 64;

  // 2-bit saturating branch counter. The msb gives the taken prediction.
  typedef enum logic [1:0] {
    CtrSnt = 2'b00,
    CtrWnt = 2'b01,
    CtrWt  = 2'b10,
    CtrSt  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic                valid;
    logic [MaxAddrW-1:0] tag;
    logic [MaxAddrW-1:0] target;
    ctr_e                ctr;
  } btb_entry_t;

  // Index width for a power-of-two BTB depth.
  function automatic int unsigned btb_idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic ctr_e ctr_inc(input ctr_e c);
    return (c == CtrSt) ? CtrSt : ctr_e'(c + 2'd1);
  endfunction

  function automatic ctr_e ctr_dec(input ctr_e c);
    return (c == CtrSnt) ? CtrSnt : ctr_e'(c - 2'd1);
  endfunction

endpackage

// File: rtl/next_pc_predictor_if.sv
// Fetch/execute-side signal bundle of the next-PC predictor.
// The master side drives stall, redirect and branch resolutions.
// The slave side (the predictor) returns the fetch address and its prediction.
interface next_pc_predictor_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              resolve_valid;
  logic [ADDR_W-1:0] resolve_pc;
  logic              resolve_taken;
  logic [ADDR_W-1:0] resolve_target;

  logic [ADDR_W-1:0] pc_o;
  logic [ADDR_W-1:0] pc_plus_4;
  logic              pred_taken_o;
  logic [ADDR_W-1:0] next_addr_o;

  modport master (
    output stall,
    output redirect,
    output redirect_pc,
    output resolve_valid,
    output resolve_pc,
    output resolve_taken,
    output resolve_target,
    input  pc_o,
    input  pc_plus_4,
    input  pred_taken_o,
    input  next_addr_o
  );

  modport slave (
    input  stall,
    input  redirect,
    input  redirect_pc,
    input  resolve_valid,
    input  resolve_pc,
    input  resolve_taken,
    input  resolve_target,
    output pc_o,
    output pc_plus_4,
    output pred_taken_o,
    output next_addr_o
  );

endinterface

// File: rtl/next_pc_predictor_btb_table.sv
// Direct-mapped branch target buffer storage.
// Two combinational read ports: fetch lookup and training probe.
// One synchronous write port.
// Reset clears every valid bit and sets every counter to weakly-not-taken.
// Tags and targets are left unreset.
module next_pc_predictor_btb_table
  import next_pc_predictor_pkg::*;
#(
  parameter int unsigned Depth = 16,
  parameter int unsigned IdxW  = btb_idx_w(Depth)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IdxW-1:0] rd_idx,
  output btb_entry_t      rd_entry,
  input  logic [IdxW-1:0] probe_idx,
  output btb_entry_t      probe_entry,
  input  logic            wr_en,
  input  logic [IdxW-1:0] wr_idx,
  input  btb_entry_t      wr_entry
);

  btb_entry_t entries [Depth];

  for (genvar g = 0; g < Depth; g++) begin : g_entry
    btb_entry_t entry_q;

    // Per-entry storage: a sync reset touches only valid/ctr; a write replaces the whole entry.
    always_ff @(posedge clk) begin
      if (!rst) begin
        entry_q.valid <= 1'b0;
        entry_q.ctr   <= CtrWnt;
      end else if (wr_en && (wr_idx == IdxW'(g))) begin
        entry_q <= wr_entry;
      end
    end

    assign entries[g] = entry_q;
  end

  // Reads see pre-edge contents, so a same-cycle write is not forwarded.
  assign rd_entry    = entries[rd_idx];
  assign probe_entry = entries[probe_idx];

endmodule

// File: rtl/next_pc_predictor.sv
// Fetch-stage next-address unit. It holds the registered PC.
// Each cycle it picks redirect, stall hold, predicted target or PC+4.
// It also trains the BTB from execute-stage branch resolutions.
module next_pc_predictor
  import next_pc_predictor_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       BTB_DEPTH = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input logic               clk,
  input logic               rst,
  next_pc_predictor_if.slave bus
);

  // ADDR_W must exceed IDX_W + 2 and must not exceed MaxAddrW.
  localparam int unsigned IdxW   = btb_idx_w(BTB_DEPTH);
  localparam int unsigned TagLsb = IdxW + 2;

  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   next_addr;
  logic [ADDR_W-1:0]   pc_plus_4;
  logic [ADDR_W-1:0]   pred_target;

  logic [IdxW-1:0]     rd_idx;
  logic [IdxW-1:0]     tr_idx;
  logic [MaxAddrW-1:0] rd_tag;
  logic [MaxAddrW-1:0] tr_tag;

  btb_entry_t          rd_entry;
  btb_entry_t          tr_entry;
  btb_entry_t          wr_entry;
  logic                wr_en;
  logic                rd_hit;
  logic                tr_hit;
  logic                pred_taken;

  // Fetch-side lookup on the current PC.
  assign rd_idx      = pc_q[TagLsb-1:2];
  assign rd_tag      = MaxAddrW'(pc_q[ADDR_W-1:TagLsb]);
  assign rd_hit      = rd_entry.valid && (rd_entry.tag == rd_tag);
  assign pred_taken  = rd_hit && rd_entry.ctr[1];
  assign pred_target = rd_entry.target[ADDR_W-1:0];
  assign pc_plus_4   = pc_q + ADDR_W'(4);

  // Training-side probe on the resolved branch address.
  assign tr_idx = bus.resolve_pc[TagLsb-1:2];
  assign tr_tag = MaxAddrW'(bus.resolve_pc[ADDR_W-1:TagLsb]);
  assign tr_hit = tr_entry.valid && (tr_entry.tag == tr_tag);

  next_pc_predictor_btb_table #(
    .Depth (BTB_DEPTH),
    .IdxW  (IdxW)
  ) u_btb_table (
    .clk         (clk),
    .rst         (rst),
    .rd_idx      (rd_idx),
    .rd_entry    (rd_entry),
    .probe_idx   (tr_idx),
    .probe_entry (tr_entry),
    .wr_en       (wr_en),
    .wr_idx      (tr_idx),
    .wr_entry    (wr_entry)
  );

  // Next-address priority: redirect, then stall hold, then predicted target, then PC+4.
  always_comb begin
    next_addr = pc_plus_4;
    if (bus.redirect) begin
      next_addr = bus.redirect_pc;
    end else if (bus.stall) begin
      next_addr = pc_q;
    end else if (pred_taken) begin
      next_addr = pred_target;
    end
  end

  // Training decision. Stall and redirect do not affect it; a not-taken miss leaves the BTB untouched.
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = tr_entry;
    if (bus.resolve_valid) begin
      if (bus.resolve_taken) begin
        wr_en           = 1'b1;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = tr_tag;
        wr_entry.target = MaxAddrW'(bus.resolve_target);
        wr_entry.ctr    = tr_hit ? ctr_inc(tr_entry.ctr) : CtrWt;
      end else if (tr_hit) begin
        wr_en        = 1'b1;
        wr_entry.ctr = ctr_dec(tr_entry.ctr);
      end
    end
  end

  // PC register: a synchronous active-low reset overrides stall and redirect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= next_addr;
    end
  end

  assign bus.pc_o         = pc_q;
  assign bus.pc_plus_4    = pc_plus_4;
  assign bus.pred_taken_o = pred_taken;
  assign bus.next_addr_o  = next_addr;

  // Branches are word aligned, so the resolve address byte offset is never looked at.
  logic unused_resolve_lsb;
  assign unused_resolve_lsb = ^bus.resolve_pc[1:0];

  if (ADDR_W < MaxAddrW) begin : g_unused_hi
    logic unused_target_hi;
    assign unused_target_hi = ^rd_entry.target[MaxAddrW-1:ADDR_W];
  end

endmodule

// File: tb/tb_next_pc_predictor.sv
// Self-checking bench for next_pc_predictor.
// A vector table drives one cycle per row. Expected outputs go to a
// scoreboard queue and are compared after the inputs settle. A second
// instance with a wrapping reset PC is checked in a hand-written sequence.
module tb_next_pc_predictor;

  localparam int unsigned AW = 32;
  localparam bit          N  = 1'b0;
  localparam bit          Y  = 1'b1;
  localparam logic [31:0] Z  = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  next_pc_predictor_if #(.ADDR_W(AW)) bus ();
  next_pc_predictor_if #(.ADDR_W(AW)) wbus ();

  next_pc_predictor #(
    .ADDR_W    (AW),
    .BTB_DEPTH (16),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  next_pc_predictor #(
    .ADDR_W    (AW),
    .BTB_DEPTH (16),
    .RESET_PC  (32'hFFFF_FFFC)
  ) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (wbus)
  );

  typedef struct {
    bit          r;
    bit          st;
    bit          rd;
    logic [31:0] rpc;
    bit          rv;
    logic [31:0] vpc;
    bit          tk;
    logic [31:0] tgt;
    logic [31:0] epc;
    bit          epred;
    logic [31:0] enext;
  } vec_t;

  typedef struct {
    int          row;
    logic [31:0] pc;
    logic [31:0] pc4;
    bit          pred;
    logic [31:0] nxt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t v(input bit r, input bit st, input bit rd, input logic [31:0] rpc,
                             input bit rv, input logic [31:0] vpc, input bit tk,
                             input logic [31:0] tgt, input logic [31:0] epc, input bit epred,
                             input logic [31:0] enext);
    vec_t t;
    t.r = r; t.st = st; t.rd = rd; t.rpc = rpc;
    t.rv = rv; t.vpc = vpc; t.tk = tk; t.tgt = tgt;
    t.epc = epc; t.epred = epred; t.enext = enext;
    return t;
  endfunction

  task automatic check(input string what, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h expected %h", what, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst                = t.r;
    bus.stall          = t.st;
    bus.redirect       = t.rd;
    bus.redirect_pc    = t.rpc;
    bus.resolve_valid  = t.rv;
    bus.resolve_pc     = t.vpc;
    bus.resolve_taken  = t.tk;
    bus.resolve_target = t.tgt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst = 1'b0;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.resolve_valid = 1'b0; bus.resolve_pc = '0; bus.resolve_taken = 1'b0;
    bus.resolve_target = '0;
    wbus.stall = 1'b0; wbus.redirect = 1'b0; wbus.redirect_pc = '0;
    wbus.resolve_valid = 1'b0; wbus.resolve_pc = '0; wbus.resolve_taken = 1'b0;
    wbus.resolve_target = '0;

    //                r  st rd rpc            rv vpc       tk tgt       | pc             pred next
    vecs.push_back(v(N, N, N, Z,            N, Z,        N, Z,        32'h0,         N, 32'h4));
    vecs.push_back(v(N, N, N, Z,            N, Z,        N, Z,        32'h0,         N, 32'h4));
    vecs.push_back(v(Y, N, N, Z,            N, Z,        N, Z,        32'h0,         N, 32'h4));
    vecs.push_back(v(Y, N, N, Z,            N, Z,        N, Z,        32'h4,         N, 32'h8));
    vecs.push_back(v(Y, N, N, Z,            N, Z,        N, Z,        32'h8,         N, 32'hC));
    vecs.push_back(v(Y, N, Y, 32'h8,        N, Z,        N, Z,        32'hC,         N, 32'h8));
    vecs.push_back(v(Y, Y, N, Z,            N, Z,        N, Z,        32'h8,         N, 32'h8));
    vecs.push_back(v(Y, Y, N, Z,            N, Z,        N, Z,        32'h8,         N, 32'h8));
    vecs.push_back(v(Y, Y, N, Z,            N, Z,        N, Z,        32'h8,         N, 32'h8));
    vecs.push_back(v(Y, Y, Y, 32'h100,      N, Z,        N, Z,        32'h8,         N, 32'h100));
    vecs.push_back(v(Y, N, N, Z,            Y, 32'h10,   Y, 32'h40,   32'h100,       N, 32'h104));
    vecs.push_back(v(Y, N, Y, 32'h10,       N, Z,        N, Z,        32'h104,       N, 32'h10));
    vecs.push_back(v(Y, N, N, Z,            N, Z,        N, Z,        32'h10,        Y, 32'h40));
    vecs.push_back(v(Y, N, N, Z,            Y, 32'h10,   Y, 32'h40,   32'h40,        N, 32'h44));
    vecs.push_back(v(Y, N, N, Z,            Y, 32'h10,   Y, 32'h40,   32'h44,        N, 32'h48));
    vecs.push_back(v(Y, N, Y, 32'h10,       Y, 32'h10,   N, Z,        32'h48,        N, 32'h10));
    vecs.push_back(v(Y, N, N, Z,            Y, 32'h10,   N, Z,        32'h10,        Y, 32'h40));
    vecs.push_back(v(Y, N, Y, 32'h10,       N, Z,        N, Z,        32'h40,        N, 32'h10));
    vecs.push_back(v(Y, N, N, Z,            Y, 32'h10,   Y, 32'h60,   32'h10,        N, 32'h14));
    vecs.push_back(v(Y, N, Y, 32'h10,       N, Z,        N, Z,        32'h14,        N, 32'h10));
    vecs.push_back(v(Y, N, N, Z,            N, Z,        N, Z,        32'h10,        Y, 32'h60));
    vecs.push_back(v(Y, N, Y, 32'h50,       N, Z,        N, Z,        32'h60,        N, 32'h50));
    vecs.push_back(v(Y, N, N, Z,            Y, 32'h50,   Y, 32'h80,   32'h50,        N, 32'h54));
    vecs.push_back(v(Y, N, Y, 32'h50,       N, Z,        N, Z,        32'h54,        N, 32'h50));
    vecs.push_back(v(Y, N, N, Z,            N, Z,        N, Z,        32'h50,        Y, 32'h80));
    vecs.push_back(v(Y, N, Y, 32'h10,       N, Z,        N, Z,        32'h80,        N, 32'h10));
    vecs.push_back(v(Y, N, N, Z,            Y, 32'h10,   N, Z,        32'h10,        N, 32'h14));
    vecs.push_back(v(Y, N, Y, 32'h50,       N, Z,        N, Z,        32'h14,        N, 32'h50));
    vecs.push_back(v(Y, N, N, Z,            Y, 32'h10,   Y, 32'h40,   32'h50,        Y, 32'h80));
    vecs.push_back(v(Y, N, Y, 32'h10,       N, Z,        N, Z,        32'h80,        N, 32'h10));
    vecs.push_back(v(N, Y, Y, 32'h200,      Y, 32'h10,   Y, 32'h40,   32'h10,        Y, 32'h200));
    vecs.push_back(v(Y, N, N, Z,            N, Z,        N, Z,        32'h0,         N, 32'h4));
    vecs.push_back(v(Y, N, Y, 32'h10,       N, Z,        N, Z,        32'h4,         N, 32'h10));
    vecs.push_back(v(Y, N, N, Z,            N, Z,        N, Z,        32'h10,        N, 32'h14));
    vecs.push_back(v(Y, N, Y, 32'hFFFF_FFFC, N, Z,       N, Z,        32'h14,        N, 32'hFFFF_FFFC));
    vecs.push_back(v(Y, N, N, Z,            N, Z,        N, Z,        32'hFFFF_FFFC, N, 32'h0));
    vecs.push_back(v(Y, N, Y, 32'h103,      N, Z,        N, Z,        32'h0,         N, 32'h103));
    vecs.push_back(v(Y, N, N, Z,            N, Z,        N, Z,        32'h103,       N, 32'h107));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      sb.push_back('{row: i, pc: vecs[i].epc, pc4: vecs[i].epc + 32'd4,
                     pred: vecs[i].epred, nxt: vecs[i].enext});
      #1;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard row %0d: got empty queue expected one entry", i);
      end else begin
        e = sb.pop_front();
        check("pc_o", e.row, bus.pc_o, e.pc);
        check("pc_plus_4", e.row, bus.pc_plus_4, e.pc4);
        check("pred_taken_o", e.row, {31'b0, bus.pred_taken_o}, {31'b0, e.pred});
        check("next_addr_o", e.row, bus.next_addr_o, e.nxt);
      end
    end

    // Wrap-around from a reset PC at the top of the address space.
    @(negedge clk);
    rst = 1'b0;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.resolve_valid = 1'b0;
    @(negedge clk);
    #1;
    check("wrap reset pc_o", -1, wbus.pc_o, 32'hFFFF_FFFC);
    check("wrap reset pc_plus_4", -1, wbus.pc_plus_4, 32'h0);
    check("wrap reset next_addr_o", -1, wbus.next_addr_o, 32'h0);
    check("wrap reset pred_taken_o", -1, {31'b0, wbus.pred_taken_o}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("wrap pc_o", -1, wbus.pc_o, 32'h0);
    check("wrap next_addr_o", -1, wbus.next_addr_o, 32'h4);
    check("main after reset pc_o", -1, bus.pc_o, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
